// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit and receive paths.
//
// Contents:
//   parity_mode_t   - decoded parity selection (none / odd / even / mark)
//   tx_state_t      - transmit framer states
//   DATA_BITS_MIN   - shortest supported data field (encoding 0)
//   DATA_BITS_MAX   - longest supported data field (encoding 3 and above)
//   last_bit_index  - maps the data_bits encoding to the index of the final
//                     data bit, clamping oversize encodings to 8 bits
//   calc_parity     - parity bit for the active data bits of a byte
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_ODD  = 2'b01,
    PARITY_EVEN = 2'b10,
    PARITY_MARK = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_t;

  // Index of the last data bit sent (N-1). Encodings 0..3 give 5..8 bits;
  // anything larger is treated as 8 bits rather than wrapping around.
  function automatic logic [2:0] last_bit_index(input logic [2:0] data_bits);
    logic [2:0] idx;
    if (data_bits > 3'd3) begin
      idx = 3'(DATA_BITS_MAX - 1);
    end else begin
      idx = 3'(DATA_BITS_MIN - 1) + data_bits;
    end
    return idx;
  endfunction

  // Parity covers only the bits that actually go on the line, so the unused
  // upper bits of a short word are masked off before reduction.
  function automatic logic calc_parity(input logic [7:0]   data,
                                       input logic [2:0]   last_idx,
                                       input parity_mode_t mode);
    logic [7:0] mask;
    logic       x;
    logic       result;
    mask = 8'hFF >> (3'd7 - last_idx);
    x    = ^(data & mask);
    case (mode)
      PARITY_ODD:  result = ~x;
      PARITY_EVEN: result = x;
      PARITY_MARK: result = 1'b1;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Reload down-counter that times one UART bit. The count runs from the
// divisor down to zero; tick is high while the count is zero, and the edge
// that sees tick reloads the divisor. Each bit therefore spans divisor+1
// clocks. A load pulse restarts the count immediately from the divisor.
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   load     - restart the bit period from divisor
//   divisor  - bit period minus one, in clocks
//   tick     - high during the last clock of a bit period
// ---------------------------------------------------------------------------
module uart_baud_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Reload on an explicit load or when the period expires, else count down.
  always_comb begin
    count_d = count_q;
    if (load || (count_q == 16'd0)) begin
      count_d = divisor;
    end else begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == 16'd0);

endmodule

// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// Serial transmit stage. Accepts bytes over a valid/ready handshake and
// sends each as one asynchronous frame: start bit, 5-8 data bits LSB first,
// optional parity bit, then one or two stop bits. The whole configuration
// is captured when a byte is accepted, so register writes during a frame
// only affect the following frame.
//
// Parameters:
//   CLOCK_FREQ     - system clock in Hz (informational; timing comes from
//                    baud_divisor)
//
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-high reset
//   baud_divisor   - each bit lasts baud_divisor+1 clocks
//   data_bits      - 0..3 selects 5..8 data bits, larger values mean 8
//   parity_mode    - 00 none, 01 odd, 10 even, 11 mark
//   two_stop_bits  - 1 sends two stop bits
//   tx_enable      - allows new bytes to be accepted
//   config_valid   - allows new bytes to be accepted
//   s_data         - byte to transmit
//   s_valid        - s_data is valid
//   s_ready        - framer can accept a byte this cycle
//   tx             - registered serial line, idles high
//   busy           - a frame is in progress
//   frame_done     - one-cycle pulse after the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_divisor,
  input  logic [2:0]  data_bits,
  input  logic [1:0]  parity_mode,
  input  logic        two_stop_bits,
  input  logic        tx_enable,
  input  logic        config_valid,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  tx_state_t    state_q,       state_d;
  logic [7:0]   shift_q,       shift_d;
  logic [2:0]   bit_idx_q,     bit_idx_d;
  logic [2:0]   last_idx_q,    last_idx_d;
  parity_mode_t parity_mode_q, parity_mode_d;
  logic         parity_bit_q,  parity_bit_d;
  logic         two_stop_q,    two_stop_d;
  logic [15:0]  divisor_q,     divisor_d;
  logic         tx_q,          tx_d;
  logic         busy_q,        busy_d;
  logic         frame_done_q,  frame_done_d;

  logic         accept;
  logic         baud_load;
  logic         baud_tick;
  logic [15:0]  baud_div_sel;
  logic [2:0]   new_last_idx;

  // Ready is held low during reset so nothing is accepted on release.
  assign s_ready = (state_q == IDLE) && tx_enable && config_valid && !reset;
  assign accept  = s_valid && s_ready;

  assign new_last_idx = last_bit_index(data_bits);

  // The accepting edge must load the incoming divisor, since the captured
  // copy is not yet valid; afterwards the captured copy drives reloads.
  assign baud_div_sel = accept ? baud_divisor : divisor_q;

  uart_baud_gen u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (baud_load),
    .divisor (baud_div_sel),
    .tick    (baud_tick)
  );

  // Next-state logic. Outside IDLE every transition waits for the baud tick
  // that ends the current bit. The line value is computed from the state
  // being entered so that tx is a clean flop output aligned with the state.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    last_idx_d    = last_idx_q;
    parity_mode_d = parity_mode_q;
    parity_bit_d  = parity_bit_q;
    two_stop_d    = two_stop_q;
    divisor_d     = divisor_q;
    frame_done_d  = 1'b0;
    baud_load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = START;
          shift_d       = s_data;
          bit_idx_d     = 3'd0;
          last_idx_d    = new_last_idx;
          parity_mode_d = parity_mode_t'(parity_mode);
          parity_bit_d  = calc_parity(s_data, new_last_idx,
                                      parity_mode_t'(parity_mode));
          two_stop_d    = two_stop_bits;
          divisor_d     = baud_divisor;
          baud_load     = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == last_idx_q) begin
            state_d = (parity_mode_q != PARITY_NONE) ? PARITY : STOP1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (baud_tick) begin
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      STOP2: begin
        if (baud_tick) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_bit_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and frame registers. Reset forces the line high at once and
  // discards any frame in flight without reporting completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= 8'd0;
      bit_idx_q     <= 3'd0;
      last_idx_q    <= 3'd7;
      parity_mode_q <= PARITY_NONE;
      parity_bit_q  <= 1'b0;
      two_stop_q    <= 1'b0;
      divisor_q     <= 16'd0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      last_idx_q    <= last_idx_d;
      parity_mode_q <= parity_mode_d;
      parity_bit_q  <= parity_bit_d;
      two_stop_q    <= two_stop_d;
      divisor_q     <= divisor_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Directed and randomized checks of uart_tx_framer. Expected line activity
// is derived from a list of frame bits (start, data LSB first, parity by
// counting ones, stops), each held for divisor+1 clocks.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_divisor;
  logic [2:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        two_stop_bits;
  logic        tx_enable;
  logic        config_valid;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  bit exp_bits[$];

  uart_tx_framer #(.CLOCK_FREQ(100_000_000)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_divisor  (baud_divisor),
    .data_bits     (data_bits),
    .parity_mode   (parity_mode),
    .two_stop_bits (two_stop_bits),
    .tx_enable     (tx_enable),
    .config_valid  (config_valid),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .tx            (tx),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit period.
  task automatic build_frame(input logic [7:0] data, input logic [2:0] db,
                             input logic [1:0] pm, input logic two);
    int n;
    int ones;
    n    = (db > 3'd3) ? 8 : int'(db) + 5;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (pm == 2'd1) exp_bits.push_back(bit'((ones % 2) == 0));
    if (pm == 2'd2) exp_bits.push_back(bit'((ones % 2) == 1));
    if (pm == 2'd3) exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    if (two) exp_bits.push_back(1'b1);
  endtask

  task automatic set_config(input logic [15:0] d, input logic [2:0] db,
                            input logic [1:0] pm, input logic two);
    baud_divisor  = d;
    data_bits     = db;
    parity_mode   = pm;
    two_stop_bits = two;
  endtask

  // Present one byte for a single handshake, then withdraw it.
  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    s_data  = data;
    s_valid = 1'b1;
    checkOutput("s_ready_idle", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Follows the line from the first start-bit cycle through frame_done.
  task automatic check_frame(input int d, input bit trailing);
    foreach (exp_bits[b]) begin
      repeat (d + 1) begin
        @(negedge clk);
        checkOutput($sformatf("tx_bit%0d", b), tx, exp_bits[b]);
        checkOutput("busy_in_frame", busy, 1'b1);
        checkOutput("no_early_done", frame_done, 1'b0);
      end
    end
    @(negedge clk);
    checkOutput("frame_done_pulse", frame_done, 1'b1);
    checkOutput("busy_cleared", busy, 1'b0);
    checkOutput("tx_idle_after", tx, 1'b1);
    if (trailing) begin
      @(negedge clk);
      checkOutput("frame_done_one_cycle", frame_done, 1'b0);
      checkOutput("tx_idle_gap", tx, 1'b1);
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [2:0]  rdb;
    logic [1:0]  rpm;
    logic        rtwo;
    logic [7:0]  rdata;

    reset        = 1'b1;
    tx_enable    = 1'b1;
    config_valid = 1'b1;
    s_valid      = 1'b0;
    s_data       = 8'h00;
    set_config(16'd16, 3'd3, 2'd0, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_frame_done", frame_done, 1'b0);
    checkOutput("reset_s_ready", s_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", s_ready, 1'b1);

    $display("[TB] 8N1 D=16 0x55");
    set_config(16'd16, 3'd3, 2'd0, 1'b0);
    build_frame(8'h55, 3'd3, 2'd0, 1'b0);
    applyStimulus(8'h55);
    check_frame(16, 1'b1);

    $display("[TB] 7E2 D=16 0x41");
    set_config(16'd16, 3'd2, 2'd2, 1'b1);
    build_frame(8'h41, 3'd2, 2'd2, 1'b1);
    applyStimulus(8'h41);
    check_frame(16, 1'b1);

    $display("[TB] 5O1 and 5M1 D=16 0x1F");
    set_config(16'd16, 3'd0, 2'd1, 1'b0);
    build_frame(8'h1F, 3'd0, 2'd1, 1'b0);
    applyStimulus(8'h1F);
    check_frame(16, 1'b1);
    set_config(16'd16, 3'd0, 2'd3, 1'b0);
    build_frame(8'h1F, 3'd0, 2'd3, 1'b0);
    applyStimulus(8'h1F);
    check_frame(16, 1'b1);

    $display("[TB] D=0 8E1 0xA7");
    set_config(16'd0, 3'd3, 2'd2, 1'b0);
    build_frame(8'hA7, 3'd3, 2'd2, 1'b0);
    applyStimulus(8'hA7);
    check_frame(0, 1'b1);

    // Back-to-back with a divisor change during the first frame.
    $display("[TB] back-to-back with mid-frame divisor write");
    set_config(16'd16, 3'd3, 2'd0, 1'b0);
    @(negedge clk);
    s_data  = 8'h3C;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_data       = 8'hC3;
    baud_divisor = 16'd32;
    build_frame(8'h3C, 3'd3, 2'd0, 1'b0);
    check_frame(16, 1'b0);
    checkOutput("s_ready_in_gap", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    build_frame(8'hC3, 3'd3, 2'd0, 1'b0);
    check_frame(32, 1'b1);

    // Acceptance gating.
    $display("[TB] enable gating");
    set_config(16'd3, 3'd3, 2'd0, 1'b0);
    s_data    = 8'h5A;
    s_valid   = 1'b1;
    tx_enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("ready_txen_low", s_ready, 1'b0);
      checkOutput("tx_txen_low", tx, 1'b1);
      checkOutput("busy_txen_low", busy, 1'b0);
    end
    tx_enable    = 1'b1;
    config_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("ready_cfg_low", s_ready, 1'b0);
      checkOutput("tx_cfg_low", tx, 1'b1);
      checkOutput("busy_cfg_low", busy, 1'b0);
    end
    s_valid      = 1'b0;
    config_valid = 1'b1;

    // Dropping tx_enable mid-frame lets the frame finish, then blocks.
    build_frame(8'h96, 3'd3, 2'd0, 1'b0);
    applyStimulus(8'h96);
    tx_enable = 1'b0;
    s_data    = 8'h11;
    s_valid   = 1'b1;
    check_frame(3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("ready_after_disable", s_ready, 1'b0);
      checkOutput("tx_after_disable", tx, 1'b1);
      checkOutput("busy_after_disable", busy, 1'b0);
    end
    s_valid   = 1'b0;
    tx_enable = 1'b1;

    // Randomized frames; config inputs are scrambled while each is in flight.
    $display("[TB] randomized frames");
    repeat (20) begin
      rd    = 16'($urandom_range(0, 4));
      rdb   = 3'($urandom_range(0, 7));
      rpm   = 2'($urandom_range(0, 3));
      rtwo  = 1'($urandom_range(0, 1));
      rdata = 8'($urandom);
      set_config(rd, rdb, rpm, rtwo);
      build_frame(rdata, rdb, rpm, rtwo);
      applyStimulus(rdata);
      set_config(16'($urandom_range(0, 9)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      s_data = 8'($urandom);
      check_frame(int'(rd), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset during a data bit.
    $display("[TB] reset mid-frame");
    set_config(16'd16, 3'd3, 2'd0, 1'b0);
    applyStimulus(8'hF0);
    repeat (22) @(posedge clk);
    #2;
    checkOutput("pre_reset_data_bit", tx, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_tx", tx, 1'b1);
    checkOutput("async_reset_busy", busy, 1'b0);
    checkOutput("async_reset_ready", s_ready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_no_done", frame_done, 1'b0);
      checkOutput("reset_tx_high", tx, 1'b1);
    end
    reset = 1'b0;
    #1;
    checkOutput("ready_after_release", s_ready, 1'b1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("release_no_done", frame_done, 1'b0);
      checkOutput("release_tx_high", tx, 1'b1);
      checkOutput("release_busy_low", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit stage that sits directly downstream of the UART configuration register block. It consumes the decoded configuration fields and a byte stream over a valid/ready handshake, then drives the `tx` line with one asynchronous frame per byte. Each frame is a start bit, 5–8 data bits sent LSB first, an optional parity bit, and 1 or 2 stop bits, with every bit timed by the baud divisor. Configuration is snapshotted at frame start, so register writes never corrupt a frame in flight.

## Interface
- `CLOCK_FREQ`, default 100_000_000: system clock frequency in Hz. Documentation only; all timing comes from `baud_divisor`.
- `clk` — in — 1: system clock, one clock domain.
- `reset` — in — 1: asynchronous, active-high reset.
- `baud_divisor` — in — 16: each bit lasts `baud_divisor+1` clocks.
- `data_bits` — in — 3: data length encoding; 0–3 selects 5–8 bits.
- `parity_mode` — in — 2: 00 none, 01 odd, 10 even, 11 mark (parity bit is 1).
- `two_stop_bits` — in — 1: 0 sends one stop bit, 1 sends two.
- `tx_enable` — in — 1: gates acceptance of new bytes.
- `config_valid` — in — 1: gates acceptance of new bytes.
- `s_data` — in — 8: byte to transmit.
- `s_valid` — in — 1: `s_data` is valid.
- `s_ready` — out — 1: block can accept a byte.
- `tx` — out — 1: serial line, idles high; registered output.
- `busy` — out — 1: a frame is in progress.
- `frame_done` — out — 1: one-cycle pulse after the final stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, state=IDLE, `s_ready`=0 while `reset` is high.
- `s_ready` = (state==IDLE) & `tx_enable` & `config_valid`. It is combinational from state and inputs, with no dependence on `s_valid`.
- A byte is accepted on a clock edge where `s_valid` & `s_ready` are both high.
- On acceptance, latch into frame registers:
  - `s_data`
  - N = `data_bits`+5; an encoding above 3 is clamped to 8 bits
  - parity mode and stop count
  - D = `baud_divisor`
- Configuration inputs are ignored until the next acceptance.
- States:
  - IDLE → START on acceptance.
  - START → DATA.
  - DATA → PARITY if mode≠none, otherwise → STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if two stop bits, otherwise → IDLE.
  - STOP2 → IDLE.
- Line value per state: START drives 0; DATA drives bit i, i=0..N-1 (LSB first); PARITY drives the parity bit; STOP1 and STOP2 drive 1.
- Parity is computed over the N data bits only:
  - odd: ~XOR of the data bits
  - even: XOR of the data bits
  - mark: 1
- `tx_enable` deasserting mid-frame does not abort; the current frame completes and no new byte is accepted.
- `config_valid` low behaves the same as `tx_enable` low.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous), and the in-flight byte is discarded with no `frame_done`.

## Timing
- Acceptance at edge k: `tx` goes 0 and `busy` goes 1 from edge k (latency 1 cycle from the sampled handshake).
- Bit counter loads D and decrements each clock. At count 0 the next edge advances to the next bit and reloads D.
- Every bit holds exactly D+1 cycles.
- Frame length F = (1+N+P+S)·(D+1) cycles, where P∈{0,1} and S∈{1,2}.
- At the edge ending the last stop bit: state goes IDLE, `busy` goes 0, and `frame_done` is high for the following cycle only.
- The earliest next acceptance is at the edge after returning to IDLE, so the back-to-back frame period is F+1 cycles and the line stays high during the gap.
- D=0 is legal and gives 1 cycle per bit. Validity policing is left to `config_valid`.

## Structure
- Shared package `uart_pkg` holds:
  - `parity_mode_t` enum: PARITY_NONE, PARITY_ODD, PARITY_EVEN, PARITY_MARK
  - `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP1, STOP2
  - constant `DATA_BITS_MIN`=5
- Natural sub-module: `uart_baud_gen`. It is a reload down-counter with inputs `load` and `divisor[15:0]` and output `tick` (asserted at count 0). The RX path reuses it.
- Framer FSM, shift register, and bit index stay in `uart_tx_framer`.

## Test plan
- D=16, 8N1, send 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 17 cycles; `frame_done` pulses 170 cycles after the first low cycle.
- D=16, 7E2, send 0x41 → 7 data bits 1,0,0,0,0,0,1, parity 0, two stop bits; F=11·17=187 cycles.
- D=16, 5O1, send 0x1F → data 1,1,1,1,1 then parity 0. The same test with mark parity gives parity 1.
- Hold `s_valid` high with two bytes queued, 8N1, D=16 → second start bit begins exactly 171 cycles after the first. A config write to D=32 mid-frame leaves the first frame at 17-cycle bits and takes effect from the second frame.
- `tx_enable`=0 or `config_valid`=0 with `s_valid`=1 → `s_ready`=0 and `tx` stays 1. Dropping `tx_enable` mid-frame still completes the frame.
- Assert `reset` during a DATA bit → `tx`=1 and `busy`=0 asynchronously, no `frame_done`, and `s_ready` is high the first cycle after release (enables high).
